ci_re_mixer: RTL and testbench

Complex-input, real-output upconversion mixer. It computes out = in_i·lo_i − in_q·lo_q in Q1.15 fixed point, with round-half-up and saturation. It sits on the transmit path between the complex baseband interpolator and the real DAC feed, and is the counterpart of the real-to-complex receive mixer. One multiplier is time-shared over a two-cycle sample slot, so throughput is one sample per two clocks.

---
 rtl/ci_re_mixer.sv | 134 +++++++++++++
 tb/tb_ci_re_mixer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ci_re_mixer.sv
// Complex-to-real upconversion mixer: out = in_i*lo_i - in_q*lo_q in Q1.15.
// One shared multiplier over a two-cycle slot, so one output per two clocks.
// Rounding is half toward +inf; the result saturates to the 16-bit range.
`timescale 1ns/1ps
module ci_re_mixer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] in_i,
  input  logic [15:0] in_q,
  input  logic [15:0] lo_i,
  input  logic [15:0] lo_q,
  output logic        in_strobe,
  output logic [15:0] out,
  output logic        out_valid
);

  localparam int unsigned DSZ = 16;

  // Slot phase: 0 captures inputs and retires a result, 1 subtracts.
  logic                      state_q, state_d;
  logic signed [DSZ-1:0]     i_buf_q, i_buf_d;
  logic signed [DSZ-1:0]     q_buf_q, q_buf_d;
  logic signed [DSZ-1:0]     li_buf_q, li_buf_d;
  logic signed [DSZ-1:0]     lq_buf_q, lq_buf_d;
  logic signed [2*DSZ-1:0]   mult_q, mult_d;
  logic signed [2*DSZ:0]     acc_q, acc_d;
  logic [DSZ-1:0]            out_q, out_d;
  logic                      valid_q, valid_d;
  // seen0 marks the first state-0 edge; primed follows on the second, so the
  // accumulator never retires a partial product left over from reset.
  logic                      seen0_q, seen0_d;
  logic                      primed_q, primed_d;

  logic [DSZ+2:0]            rnd;
  logic signed [DSZ+1:0]     rnd_trunc;
  logic [DSZ-1:0]            sat_val;

  // Clamp an 18-bit signed value into 16 bits.
  function automatic logic [DSZ-1:0] sat18(input logic signed [DSZ+1:0] v);
    logic [DSZ-1:0] r;
    if ((v[DSZ+1] == v[DSZ]) && (v[DSZ] == v[DSZ-1])) begin
      r = v[DSZ-1:0];
    end else if (v[DSZ+1]) begin
      r = 16'h8000;
    end else begin
      r = 16'h7fff;
    end
    return r;
  endfunction

  // Round half-up: drop 14 LSBs, add one, then drop one more.
  always_comb begin
    rnd       = 19'(acc_q >>> (DSZ - 2)) + 19'd1;
    rnd_trunc = 18'(rnd >> 1);
    sat_val   = sat18(rnd_trunc);
  end

  // Next-state logic for the two-phase datapath; en low holds everything.
  always_comb begin
    state_d  = state_q;
    i_buf_d  = i_buf_q;
    q_buf_d  = q_buf_q;
    li_buf_d = li_buf_q;
    lq_buf_d = lq_buf_q;
    mult_d   = mult_q;
    acc_d    = acc_q;
    out_d    = out_q;
    valid_d  = valid_q;
    seen0_d  = seen0_q;
    primed_d = primed_q;
    if (en) begin
      state_d = ~state_q;
      if (!state_q) begin
        i_buf_d  = in_i;
        q_buf_d  = in_q;
        li_buf_d = lo_i;
        lq_buf_d = lo_q;
        acc_d    = 33'(mult_q);
        // Uses the buffers of the slot being finished, not the new capture.
        mult_d   = 32'(q_buf_q) * 32'(lq_buf_q);
        seen0_d  = 1'b1;
        if (seen0_q) begin
          primed_d = 1'b1;
        end
        if (primed_q) begin
          out_d   = sat_val;
          valid_d = 1'b1;
        end
      end else begin
        mult_d  = 32'(i_buf_q) * 32'(li_buf_q);
        acc_d   = acc_q - 33'(mult_q);
        valid_d = 1'b0;
      end
    end
  end

  // State register with asynchronous clear of the whole pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= 1'b0;
      i_buf_q  <= '0;
      q_buf_q  <= '0;
      li_buf_q <= '0;
      lq_buf_q <= '0;
      mult_q   <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      seen0_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_buf_q  <= i_buf_d;
      q_buf_q  <= q_buf_d;
      li_buf_q <= li_buf_d;
      lq_buf_q <= lq_buf_d;
      mult_q   <= mult_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      seen0_q  <= seen0_d;
      primed_q <= primed_d;
    end
  end

  // Strobe is gated by reset so upstream never advances while held in reset.
  always_comb begin
    in_strobe = reset_n & en & ~state_q;
    out       = out_q;
    out_valid = valid_q;
  end

endmodule

// File: tb/tb_ci_re_mixer.sv
// Self-checking bench for ci_re_mixer: directed vectors, a ramp with random
// enable gaps, random data, and an asynchronous reset in mid-slot.
`timescale 1ns/1ps
module tb_ci_re_mixer;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [15:0] in_i, in_q, lo_i, lo_q;
  logic        in_strobe;
  logic [15:0] out;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  ci_re_mixer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .in_i      (in_i),
    .in_q      (in_q),
    .lo_i      (lo_i),
    .lo_q      (lo_q),
    .in_strobe (in_strobe),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: slot phase, enabled-edge index, captured samples.
  typedef struct {
    logic [15:0] val;
    int          idx;
  } cap_t;

  cap_t        cq[$];
  int          ph;
  int          ecnt;
  int          edges;
  logic [15:0] exp_out;
  logic        exp_valid;
  logic        first_arm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mix(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
    longint p;
    p = longint'($signed(a)) * longint'($signed(c)) - longint'($signed(b)) * longint'($signed(d));
    p = (p + 64'sd16384) >>> 15;
    if (p > 64'sd32767) return 16'h7fff;
    if (p < -64'sd32768) return 16'h8000;
    return p[15:0];
  endfunction

  task automatic model_clear();
    cq.delete();
    ph        = 0;
    ecnt      = 0;
    edges     = 0;
    exp_out   = 16'h0;
    exp_valid = 1'b0;
  endtask

  // One clock: drive en, check strobe, advance the model on the edge, check outputs.
  task automatic step(input logic e, output logic cap);
    cap_t c;
    en  = e;
    cap = 1'b0;
    #1;
    chk("in_strobe", {31'd0, in_strobe}, {31'd0, (e && ph == 0)});
    @(posedge clk);
    edges++;
    if (e) begin
      if (ph == 0) begin
        if (cq.size() > 0 && cq[0].idx == ecnt - 4) begin
          c         = cq.pop_front();
          exp_out   = c.val;
          exp_valid = 1'b1;
        end
        c.val = ref_mix(in_i, in_q, lo_i, lo_q);
        c.idx = ecnt;
        cq.push_back(c);
        cap = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      ph ^= 1;
      ecnt++;
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    chk("out", {16'd0, out}, {16'd0, exp_out});
    if (first_arm && out_valid) begin
      chk("first_pulse_edge", edges, 5);
      first_arm = 1'b0;
    end
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear at once.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_out", {16'd0, out}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_strobe", {31'd0, in_strobe}, 32'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    model_clear();
    first_arm = 1'b1;
  endtask

  logic [15:0] vec [10][5];
  logic        cap;
  logic [15:0] ramp;

  initial begin
    // {in_i, in_q, lo_i, lo_q, expected}
    vec[0] = '{16'h4000, 16'h0000, 16'h4000, 16'h0000, 16'h2000};
    vec[1] = '{16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'he000};
    vec[2] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0000};
    vec[3] = '{16'h8000, 16'h7fff, 16'h8000, 16'h8000, 16'h7fff};
    vec[4] = '{16'h8000, 16'h7fff, 16'h7fff, 16'h7fff, 16'h8000};
    vec[5] = '{16'h0001, 16'h0000, 16'h4000, 16'h0000, 16'h0001};
    vec[6] = '{16'hffff, 16'h0000, 16'h4000, 16'h0000, 16'h0000};
    vec[7] = '{16'h0001, 16'h0000, 16'h3fff, 16'h0000, 16'h0000};
    vec[8] = '{16'h7fff, 16'h0000, 16'h7fff, 16'h0000, 16'h7ffe};
    vec[9] = '{16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h7fff};

    reset_n   = 1'b0;
    en        = 1'b0;
    in_i      = 16'h0;
    in_q      = 16'h0;
    lo_i      = 16'h0;
    lo_q      = 16'h0;
    first_arm = 1'b0;
    model_clear();
    #1;
    chk("init_out", {16'd0, out}, 32'd0);
    chk("init_valid", {31'd0, out_valid}, 32'd0);
    chk("init_strobe", {31'd0, in_strobe}, 32'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    // Directed vectors, each from a fresh reset with en held high.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      in_i = vec[v][0];
      in_q = vec[v][1];
      lo_i = vec[v][2];
      lo_q = vec[v][3];
      for (int k = 0; k < 10; k++) step(1'b1, cap);
      chk($sformatf("vec%0d_const", v), {16'd0, out}, {16'd0, vec[v][4]});
    end

    // Ramp on in_i with random enable gaps; each capture gets the next value.
    do_reset();
    first_arm = 1'b0;
    ramp = 16'd1;
    in_q = 16'h0;
    lo_q = 16'h0;
    lo_i = 16'h7fff;
    for (int k = 0; k < 400; k++) begin
      in_i = ramp;
      step(($urandom_range(0, 2) != 0), cap);
      if (cap) ramp++;
    end
    for (int k = 0; k < 8; k++) begin
      in_i = ramp;
      step(1'b1, cap);
      if (cap) ramp++;
    end

    // Random data with random enables, then a reset right after a state-0 edge
    // late in the pipeline while the accumulator holds non-zero data.
    for (int k = 0; k < 600; k++) begin
      in_i = 16'($urandom);
      in_q = 16'($urandom);
      lo_i = 16'($urandom);
      lo_q = 16'($urandom);
      if (k == 300) begin
        while (!(ph == 1 && ecnt >= 7 && out != 16'h0)) begin
          step(1'b1, cap);
          in_i = 16'($urandom) | 16'h1000;
          lo_i = 16'h7fff;
        end
        do_reset();
        for (int j = 0; j < 12; j++) begin
          in_i = 16'($urandom);
          in_q = 16'($urandom);
          lo_i = 16'($urandom);
          lo_q = 16'($urandom);
          step(1'b1, cap);
        end
        chk("post_reset_first_seen", {31'd0, first_arm}, 32'd0);
      end
      step(($urandom_range(0, 3) != 0), cap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
